// File: rtl/sha_pkg.sv
// sha_pkg: shared constants, state encoding and rotate helpers for the SHA message schedule
package sha_pkg;
    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    localparam int S0_256_A = 7;
    localparam int S0_256_B = 18;
    localparam int S0_256_C = 3;
    localparam int S1_256_A = 17;
    localparam int S1_256_B = 19;
    localparam int S1_256_C = 10;
    localparam int S0_512_A = 1;
    localparam int S0_512_B = 8;
    localparam int S0_512_C = 7;
    localparam int S1_512_A = 19;
    localparam int S1_512_B = 61;
    localparam int S1_512_C = 6;
    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
endpackage

// File: rtl/sha_sched_sigma.sv
// sha_sched_sigma: combinational small-sigma pair, returns s0(x_s0) + s1(x_s1) for the selected word size
module sha_sched_sigma
    import sha_pkg::*;
(
    input  logic        mode,
    input  logic [63:0] x_s0,
    input  logic [63:0] x_s1,
    output logic [63:0] sum
);
    logic [31:0] s0_32, s1_32;
    logic [63:0] s0_64, s1_64;
    assign s0_32 = rotr32(x_s0[31:0], S0_256_A) ^ rotr32(x_s0[31:0], S0_256_B) ^ (x_s0[31:0] >> S0_256_C);
    assign s1_32 = rotr32(x_s1[31:0], S1_256_A) ^ rotr32(x_s1[31:0], S1_256_B) ^ (x_s1[31:0] >> S1_256_C);
    assign s0_64 = rotr64(x_s0, S0_512_A) ^ rotr64(x_s0, S0_512_B) ^ (x_s0 >> S0_512_C);
    assign s1_64 = rotr64(x_s1, S1_512_A) ^ rotr64(x_s1, S1_512_B) ^ (x_s1 >> S1_512_C);
    assign sum = mode ? s0_64 + s1_64 : {32'h0, s0_32 + s1_32};
endmodule

// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule: loads a padded block and streams W[t] over a valid/ready handshake for SHA-256/512
module sha_msg_schedule
    import sha_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [1023:0] block_in,
    input  logic          w_ready,
    output logic          w_valid,
    output logic [63:0]   w_out,
    output logic [6:0]    round_idx,
    output logic          busy,
    output logic          done
);
    state_t      state;
    logic        mode_q;
    logic [63:0] r [16];
    logic [63:0] sig_sum, add, w_new;
    logic [6:0]  last;
    logic        hs;

    sha_sched_sigma u_sigma (
        .mode (mode_q),
        .x_s0 (r[1]),
        .x_s1 (r[14]),
        .sum  (sig_sum)
    );

    assign add   = sig_sum + r[9] + r[0];
    assign w_new = mode_q ? add : {32'h0, add[31:0]};
    assign last  = mode_q ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
    assign hs    = w_valid & w_ready;
    assign w_out = r[0];

    // FSM with window shift: load on start, slide one word per handshake, pulse done after the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= 1'b0;
            round_idx <= '0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) r[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mode_q    <= mode;
                    for (int i = 0; i < 16; i++)
                        r[i] <= mode ? block_in[1023 - 64*i -: 64] : {32'h0, block_in[511 - 32*i -: 32]};
                    round_idx <= '0;
                    w_valid   <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: if (hs) begin
                    for (int i = 0; i < 15; i++) r[i] <= r[i+1];
                    r[15]     <= w_new;
                    round_idx <= round_idx + 7'd1;
                    if (round_idx == last) begin
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_msg_schedule.sv
// tb_sha_msg_schedule: randomized self-checking bench against a full-array schedule model
module tb_sha_msg_schedule;
    logic          clk = 0, rst_n = 0, start = 0, mode = 0, w_ready = 0;
    logic [1023:0] block_in = '0;
    logic          w_valid, busy, done;
    logic [63:0]   w_out;
    logic [6:0]    round_idx;
    int            vectors = 0, miscompares = 0;
    logic [63:0]   exp_w [80];
    logic [63:0]   got_w [80];
    logic [6:0]    got_idx [80];
    int            got_n, stall_err, early_done, run_err;
    logic          done1, done2, wv_after, busy_after, wv_idle;
    logic [1023:0] abc256, abc512;

    always #5 clk = ~clk;

    sha_msg_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .block_in(block_in),
        .w_ready(w_ready), .w_valid(w_valid), .w_out(w_out), .round_idx(round_idx),
        .busy(busy), .done(done)
    );

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction
    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction
    function automatic logic [31:0] ss0_256(input logic [31:0] x); return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1_256(input logic [31:0] x); return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10); endfunction
    function automatic logic [63:0] ss0_512(input logic [63:0] x); return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7); endfunction
    function automatic logic [63:0] ss1_512(input logic [63:0] x); return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6); endfunction

    // Whole schedule as a flat array, straight from the recurrence
    function automatic void model(input logic [1023:0] b, input logic m);
        for (int t = 0; t < 80; t++) begin
            if (t < 16) exp_w[t] = m ? b[1023 - 64*t -: 64] : {32'h0, b[511 - 32*t -: 32]};
            else if (m) exp_w[t] = ss1_512(exp_w[t-2]) + exp_w[t-7] + ss0_512(exp_w[t-15]) + exp_w[t-16];
            else exp_w[t] = {32'h0, ss1_256(exp_w[t-2][31:0]) + exp_w[t-7][31:0]
                                  + ss0_256(exp_w[t-15][31:0]) + exp_w[t-16][31:0]};
        end
    endfunction

    function automatic logic [1023:0] rand_block();
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Drives one block and records every accepted word; no judging here
    task automatic run_block(input logic [1023:0] blk, input logic m, input bit bp,
                             input int poke_at, input int abort_at, input bit poke_done);
        int need = m ? 80 : 64;
        int left = 0;
        bit hold = 0, rdy = 1;
        logic [63:0] hw = '0;
        logic [6:0] hi = '0;
        got_n = 0; stall_err = 0; early_done = 0; run_err = 0;
        block_in = blk; mode = m; start = 1;
        @(posedge clk); #1;
        start = 0; block_in = rand_block(); mode = ~m;
        for (int cyc = 0; cyc < 2000 && got_n < need; cyc++) begin
            if (abort_at >= 0 && got_n == abort_at) return;
            if (bp) begin
                if (left == 0) begin rdy = ~rdy; left = $urandom_range(3, 2); end
                left--;
                w_ready = rdy;
            end else w_ready = 1;
            start = (cyc == poke_at);
            if (start) block_in = rand_block();
            if (hold && (w_out !== hw || round_idx !== hi)) stall_err++;
            if (done) early_done++;
            if (!busy || !w_valid) run_err++;
            hold = w_valid && !w_ready; hw = w_out; hi = round_idx;
            if (w_valid && w_ready) begin got_w[got_n] = w_out; got_idx[got_n] = round_idx; got_n++; end
            @(posedge clk); #1;
        end
        start = 0; w_ready = 0;
        done1 = done; wv_after = w_valid; busy_after = busy;
        if (poke_done) begin start = 1; block_in = rand_block(); mode = ~m; end
        @(posedge clk); #1;
        start = 0;
        done2 = done; wv_idle = w_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({w_valid, busy, done, round_idx, w_out} !== '0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b busy=%b done=%b idx=%0d w=%h, want all 0", w_valid, busy, done, round_idx, w_out);
        end
        rst_n = 1;
        @(posedge clk); #1;
        vectors++;
        if (w_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got valid=%b busy=%b, want 0 0", w_valid, busy);
        end
    endtask

    task automatic test_sha256_abc();
        model(abc256, 0);
        run_block(abc256, 0, 0, -1, -1, 0);
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i)) begin
                miscompares++;
                $display("FAIL abc256 word %0d: got w=%h idx=%0d, want w=%h idx=%0d", i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
        vectors++;
        if (got_w[16] !== 64'h61626380 || got_w[17] !== 64'h000F0000) begin
            miscompares++;
            $display("FAIL abc256_known: got W16=%h W17=%h, want 61626380 000f0000", got_w[16], got_w[17]);
        end
        vectors++;
        if ({got_n, stall_err, early_done, run_err} !== {32'd64, 32'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL abc256_proto: got n=%0d stall=%0d early=%0d run=%0d, want 64 0 0 0", got_n, stall_err, early_done, run_err);
        end
        vectors++;
        if ({done1, done2, wv_after, busy_after, wv_idle} !== 5'b10000) begin
            miscompares++;
            $display("FAIL abc256_done: got done1/done2/valid/busy/idle=%b, want 10000", {done1, done2, wv_after, busy_after, wv_idle});
        end
    endtask

    task automatic test_sha512_abc(input string name);
        model(abc512, 1);
        run_block(abc512, 1, 0, -1, -1, 0);
        for (int i = 0; i < 80; i++) begin
            vectors++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i)) begin
                miscompares++;
                $display("FAIL %s word %0d: got w=%h idx=%0d, want w=%h idx=%0d", name, i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
        vectors++;
        if (got_w[16] !== 64'h6162638000000000 || got_idx[79] !== 7'd79) begin
            miscompares++;
            $display("FAIL %s_known: got W16=%h last idx=%0d, want 6162638000000000 79", name, got_w[16], got_idx[79]);
        end
        vectors++;
        if ({got_n, early_done, run_err} !== {32'd80, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL %s_proto: got n=%0d early=%0d run=%0d, want 80 0 0", name, got_n, early_done, run_err);
        end
        vectors++;
        if ({done1, done2, wv_after, busy_after, wv_idle} !== 5'b10000) begin
            miscompares++;
            $display("FAIL %s_done: got done1/done2/valid/busy/idle=%b, want 10000", name, {done1, done2, wv_after, busy_after, wv_idle});
        end
    endtask

    task automatic test_backpressure();
        model(abc256, 0);
        run_block(abc256, 0, 1, -1, -1, 0);
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i)) begin
                miscompares++;
                $display("FAIL bp word %0d: got w=%h idx=%0d, want w=%h idx=%0d", i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
        vectors++;
        if ({got_n, stall_err, early_done, run_err} !== {32'd64, 32'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL bp_proto: got n=%0d stall=%0d early=%0d run=%0d, want 64 0 0 0", got_n, stall_err, early_done, run_err);
        end
        vectors++;
        if ({done1, done2, wv_after, busy_after} !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_done: got done1/done2/valid/busy=%b, want 1000", {done1, done2, wv_after, busy_after});
        end
    endtask

    task automatic test_start_ignored();
        logic [1023:0] b = rand_block();
        model(b, 1);
        run_block(b, 1, 1, 30, -1, 1);
        for (int i = 0; i < 80; i++) begin
            vectors++;
            if (got_w[i] !== exp_w[i]) begin
                miscompares++;
                $display("FAIL ign word %0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
        vectors++;
        if ({got_n, stall_err, early_done, run_err} !== {32'd80, 32'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL ign_proto: got n=%0d stall=%0d early=%0d run=%0d, want 80 0 0 0", got_n, stall_err, early_done, run_err);
        end
        vectors++;
        if ({done1, done2, wv_after, busy_after, wv_idle} !== 5'b10000) begin
            miscompares++;
            $display("FAIL ign_done: got done1/done2/valid/busy/idle=%b, want 10000", {done1, done2, wv_after, busy_after, wv_idle});
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        run_block(abc512, 1, 0, -1, 20, 0);
        vectors++;
        if (got_n !== 20 || round_idx !== 7'd20) begin
            miscompares++;
            $display("FAIL rst_mid_reach: got n=%0d idx=%0d, want 20 20", got_n, round_idx);
        end
        rst_n = 0;
        #1;
        vectors++;
        if ({w_valid, busy, done, round_idx, w_out} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_clear: got valid=%b busy=%b done=%b idx=%0d w=%h, want all 0", w_valid, busy, done, round_idx, w_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || w_valid) seen++;
        end
        rst_n = 1;
        @(posedge clk); #1;
        if (done || w_valid) seen++;
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got %0d cycles with done/valid, want 0", seen);
        end
        test_sha512_abc("restart512");
    endtask

    task automatic test_mode0_upper();
        logic [1023:0] b = rand_block();
        int hi_err = 0;
        b[1023:512] = '1;
        model(b, 0);
        run_block(b, 0, 0, -1, -1, 0);
        for (int i = 0; i < 64; i++) begin
            if (got_w[i][63:32] !== 32'h0) hi_err++;
            vectors++;
            if (got_w[i] !== exp_w[i]) begin
                miscompares++;
                $display("FAIL upper word %0d: got %h, want %h", i, got_w[i], exp_w[i]);
            end
        end
        vectors++;
        if (hi_err !== 0 || got_n !== 64) begin
            miscompares++;
            $display("FAIL upper_zero: got %0d words with nonzero top half, n=%0d, want 0 64", hi_err, got_n);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            logic [1023:0] b = rand_block();
            logic m = 1'($urandom_range(1));
            int need = m ? 80 : 64;
            int bad = 0;
            model(b, m);
            run_block(b, m, 1'($urandom_range(1)), -1, -1, 0);
            for (int i = 0; i < need; i++) if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i)) bad++;
            vectors++;
            if (bad !== 0 || got_n !== need || stall_err !== 0 || done1 !== 1'b1 || done2 !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d mode=%0d: got %0d bad words n=%0d stall=%0d done=%b%b, want 0 %0d 0 10",
                         k, m, bad, got_n, stall_err, done1, done2, need);
            end
        end
    endtask

    initial begin
        abc256 = '0;
        abc256[511:480] = 32'h61626380;
        abc256[31:0] = 32'h18;
        abc512 = '0;
        abc512[1023:960] = 64'h6162638000000000;
        abc512[63:0] = 64'h18;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sha256_abc();
        test_sha512_abc("abc512");
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_mode0_upper();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
